// File: rtl/c6_seq_divider_if.sv
// Handshake and operand/result bundle for the c6 sequential divider.
// The master side issues requests; the slave side is the divider.
interface c6_seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/c6_seq_divider.sv
// Unsigned restoring divider producing one quotient bit per clock, MSB first.
// Results are held from one done pulse to the next; a zero divisor finishes in one cycle.
module c6_seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    c6_seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH:0]   prem_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] rem_r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;

    logic             accept_s;
    logic             zero_div_s;
    logic             last_iter_s;
    logic             qbit_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH:0]   prem_next_s;
    logic [WIDTH-1:0] quot_next_s;

    // One restoring step plus next-state selection
    always_comb begin
        accept_s     = bus.start && (state_r != RUN);
        zero_div_s   = (bus.divisor == {WIDTH{1'b0}});
        last_iter_s  = (cnt_r == CW'(1));
        // The partial remainder never exceeds the divisor, so dropping its top bit on shift is lossless
        shifted_s    = (prem_r << 1) | {{WIDTH{1'b0}}, dvd_r[WIDTH-1]};
        trial_s      = shifted_s - {1'b0, dvs_r};
        qbit_s       = (shifted_s >= {1'b0, dvs_r});
        prem_next_s  = qbit_s ? trial_s : shifted_s;
        quot_next_s  = {dvd_r[WIDTH-2:0], qbit_s};
        state_next_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_next_s = zero_div_s ? DONE : RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_iter_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == RUN);
            done_r  <= (state_next_s == DONE);
        end
    end

    // Operand capture, iteration datapath and held results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CW{1'b0}};
            prem_r <= {(WIDTH + 1){1'b0}};
            dvd_r  <= {WIDTH{1'b0}};
            dvs_r  <= {WIDTH{1'b0}};
            quot_r <= {WIDTH{1'b0}};
            rem_r  <= {WIDTH{1'b0}};
            dbz_r  <= 1'b0;
        end else if (accept_s) begin
            dvd_r  <= bus.dividend;
            dvs_r  <= bus.divisor;
            prem_r <= {(WIDTH + 1){1'b0}};
            if (zero_div_s) begin
                cnt_r  <= {CW{1'b0}};
                quot_r <= {WIDTH{1'b1}};
                rem_r  <= bus.dividend;
                dbz_r  <= 1'b1;
            end else begin
                cnt_r  <= CW'(WIDTH);
            end
        end else if (state_r == RUN) begin
            dvd_r  <= quot_next_s;
            prem_r <= prem_next_s;
            cnt_r  <= cnt_r - CW'(1);
            if (last_iter_s) begin
                quot_r <= quot_next_s;
                rem_r  <= prem_next_s[WIDTH-1:0];
                dbz_r  <= 1'b0;
            end
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quot_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: doc/c6_seq_divider.md
C6_SEQ_DIVIDER -- requirements
Module: c6_seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a division; sampled only when busy=0.
REQ-005 SHALL have port dividend  input  WIDTH  unsigned numerator; captured on an accepted start.
REQ-006 SHALL have port divisor  input  WIDTH  unsigned denominator; captured on an accepted start.
REQ-007 SHALL have port busy  output  1  high while an accepted division is iterating.
REQ-008 SHALL have port done  output  1  one-cycle pulse; results valid in that cycle.
REQ-009 SHALL have port quotient  output  WIDTH  registered quotient.
REQ-010 SHALL have port remainder  output  WIDTH  registered remainder.
REQ-011 SHALL have port div_by_zero  output  1  registered flag; set when the last accepted divisor was 0.

Function
REQ-012 SHALL implement an unsigned restoring divider, one quotient bit per clock, MSB first.
REQ-013 SHALL use three states: IDLE, RUN, DONE.
REQ-014 SHALL accept start when state is IDLE or DONE (busy=0); start while busy=1 SHALL be ignored with no effect on state, operands or outputs.
REQ-015 On accepted start with divisor!=0 at edge N: capture operands, clear partial remainder, load iteration counter with WIDTH, enter RUN; busy=1 from N+1.
REQ-016 In RUN, each edge: shift {partial remainder, dividend MSB} left by one; if shifted value >= divisor, subtract divisor and shift in quotient bit 1, else 0; decrement counter.
REQ-017 Internal partial remainder SHALL be WIDTH+1 bits so the compare/subtract never overflows for divisor up to 2^WIDTH-1.
REQ-018 After WIDTH RUN cycles, at edge N+WIDTH+1: enter DONE, busy=0, done=1, quotient and remainder updated, div_by_zero=0; total latency start-to-done = WIDTH+1 cycles.
REQ-019 DONE SHALL last exactly one cycle, then go to IDLE unless a new start is accepted in DONE, in which case go to RUN (back-to-back operation, no bubble).
REQ-020 On accepted start with divisor==0 at edge N: skip RUN, enter DONE at N+1 with quotient=all ones, remainder=dividend, div_by_zero=1.
REQ-021 quotient, remainder, div_by_zero SHALL hold their values from the last DONE until the next DONE; they SHALL NOT show intermediate iteration values.
REQ-022 Result SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for all divisor!=0.
REQ-023 Changes on dividend/divisor after an accepted start SHALL NOT affect the running operation.

Reset
REQ-024 rst_n=0 SHALL immediately (asynchronously) force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
REQ-025 Reset asserted mid-RUN SHALL abandon the operation; no done pulse SHALL follow deassertion.
REQ-026 First start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-027 WIDTH=8, dividend=100, divisor=7 -> done 9 cycles after start edge, quotient=14, remainder=2, div_by_zero=0.
REQ-028 dividend=255/divisor=1 -> quotient=255, remainder=0; dividend=5/divisor=10 -> quotient=0, remainder=5; dividend=200/divisor=255 -> quotient=0, remainder=200.
REQ-029 dividend=37, divisor=0 -> done 1 cycle after start, quotient=255, remainder=37, div_by_zero=1; next 100/7 clears div_by_zero.
REQ-030 start pulsed with 50/3 while busy from a prior 100/7 -> ignored; done shows 14/2; exactly one done pulse.
REQ-031 start held high continuously with constant 100/7 -> done every 9 cycles, busy low only in DONE cycles.
REQ-032 rst_n low for one cycle at RUN cycle 4 -> all outputs 0 immediately, no done pulse; subsequent 9/2 -> quotient=4, remainder=1.
